sr_flag_bank: RTL and testbench
===============================

# sr_flag_bank

Parametrised bank of WIDTH independent set/reset flag bits with selectable conflict mode (reset-dominant, set-dominant, JK toggle), a global tick enable, synchronous bulk preset/clear, per-bit change strobes, and a first-event capture register. Replaces groups of single-bit SR flip-flops used as status/stop/run flags in the control path. It gives the control unit one registered vector and reports which flag rose first since the last acknowledge.

## Interface
- WIDTH, 8: number of flag bits; legal range 1..64.
- MODE, 0: conflict handling when s[i] and r[i] are both 1. 0 = reset-dominant, 1 = set-dominant, 2 = JK (toggle).
- INIT, 0: WIDTH-bit value loaded into q on async reset.
- IDXW is derived, not overridable: max(1, ceil(log2(WIDTH))).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- resetBar  in  1  asynchronous, active-low reset.
- tick  in  1  per-bit s/r update enable.
- clear  in  1  synchronous bulk clear of q to all zeros; ignores tick.
- preset  in  1  synchronous bulk set of q to all ones; ignores tick.
- s  in  WIDTH  per-bit set request.
- r  in  WIDTH  per-bit reset request.
- ack  in  1  acknowledge; releases the first-event capture.
- q  out  WIDTH  flag state.
- qBar  out  WIDTH  bitwise complement of q.
- changed  out  WIDTH  bit i high for one cycle after q[i] changed at the previous edge.
- anySet  out  1  OR-reduction of q (combinational from the q register).
- firstValid  out  1  a 0->1 flag event is captured and not yet acknowledged.
- firstIndex  out  IDXW  index of the captured first-rising bit.

## Operation
- Reset (resetBar low, asynchronous) sets: q = INIT, changed = 0, firstValid = 0, firstIndex = 0. The INIT value itself does not produce a changed strobe or a capture.
- Next-state priority at each rising edge: clear > preset > (tick ? per-bit update : hold).
- Per-bit update with tick = 1, for each combination of s and r:
  - 00: hold.
  - 10: set to 1.
  - 01: set to 0.
  - 11, MODE 0: 0.
  - 11, MODE 1: 1.
  - 11, MODE 2: ~q[i].
- MODE outside 0..2 behaves as MODE 0.
- changed: registered as q_next XOR q_current, so it is high exactly during the cycle in which q shows the new value. Any cause sets it: clear, preset or tick update.
- rise vector: q_next AND NOT q_current.
- First-event capture (registered):
  - When firstValid = 0 (or ack = 1), and rise is nonzero: firstValid <= 1, firstIndex <= lowest index i with rise[i] = 1.
  - Else when ack = 1 and rise = 0: firstValid <= 0; firstIndex holds its last value.
  - Else when firstValid = 1 and ack = 0: hold. Later rises are ignored.
- ack with firstValid = 0 and no rise: no effect.
- qBar is ~q at all times, including during reset.

## Timing
- Single clock domain; only resetBar is asynchronous.
- Release of resetBar is synchronised externally. The first functional edge is the first rising clock edge after release.
- Input-to-output latency is one edge: inputs sampled at edge N appear on q, changed, firstValid and firstIndex immediately after edge N.
- anySet and qBar are combinational from q. They add no latency and have no glitch requirement beyond q.
- Simultaneous cases:
  - clear and preset both high: result is all zeros, and changed reflects the 1->0 transitions.
  - ack and a new rise at the same edge: the new event is captured; firstValid stays 1 and firstIndex is updated.
- resetBar asserted mid-operation: all state returns to reset values within the reset assertion, with no clock needed.
  - A pending capture is lost.
  - No changed strobe is generated on reset entry or exit.
- tick low blocks only s/r updates. clear, preset, changed and capture still operate.

## Test plan
- Reset and idle, WIDTH=8, INIT=8'hA5: hold resetBar low, then release -> q=A5, qBar=5A, changed=00, anySet=1, firstValid=0. No strobe on the first clock.
- Mode sweep, s=r=8'h01 with tick=1, starting from q=00:
  - MODE 0 -> q stays 00.
  - MODE 1 -> q=01, changed=01 for one cycle.
  - MODE 2 -> q toggles 01, 00, 01 on successive edges.
- Capture, q=00 and ack=0:
  - s=8'h28 for one edge -> firstValid=1, firstIndex=3.
  - Next edge, s=8'h80 -> q=A8, firstIndex still 3.
  - Then ack=1 with s=r=0 -> firstValid=0.
- Ack collision: firstValid=1 and firstIndex=3; drive ack=1 and s=8'h40 on the same edge -> firstValid=1, firstIndex=6.
- Priority and enable, q=0F: tick=0, s=F0 -> q=0F unchanged; then clear=1 and preset=1 together -> q=00, changed=0F.
- Async reset mid-capture: firstValid=1 and q=FF; pulse resetBar low between edges -> q=INIT and firstValid=0 immediately, with no changed pulse after release.

Source files
------------

// File: rtl/sr_flag_bank.sv
// ============================================================================
// Module   : sr_flag_bank
// Purpose  : Bank of independent set/reset flags with a selectable conflict
//            mode, bulk clear/preset, change strobes and first-rise capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_flag_bank #(
    parameter int               WIDTH = 8,
    parameter int               MODE  = 0,
    parameter logic [WIDTH-1:0] INIT  = '0,
    localparam int              IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clock,
    input  logic             resetBar,
    input  logic             tick,
    input  logic             clear,
    input  logic             preset,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qBar,
    output logic [WIDTH-1:0] changed,
    output logic             anySet,
    output logic             firstValid,
    output logic [IDXW-1:0]  firstIndex
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_changed;
    logic             r_first_valid;
    logic [IDXW-1:0]  r_first_index;

    logic [WIDTH-1:0] w_q_upd;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_rise;
    logic [IDXW-1:0]  w_low_idx;
    logic             w_capture;

    // Both-requests-high resolution; unknown modes fall back to reset-dominant.
    always_comb begin
        w_q_upd = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({s[i], r[i]})
                2'b10:   w_q_upd[i] = 1'b1;
                2'b01:   w_q_upd[i] = 1'b0;
                2'b11: begin
                    if (MODE == 1)
                        w_q_upd[i] = 1'b1;
                    else if (MODE == 2)
                        w_q_upd[i] = ~r_q[i];
                    else
                        w_q_upd[i] = 1'b0;
                end
                default: w_q_upd[i] = r_q[i];
            endcase
        end
    end

    always_comb begin
        if (clear)
            w_q_next = '0;
        else if (preset)
            w_q_next = '1;
        else if (tick)
            w_q_next = w_q_upd;
        else
            w_q_next = r_q;
    end

    assign w_rise = w_q_next & ~r_q;

    // Scan from the top so the lowest rising index wins.
    always_comb begin
        w_low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_rise[i])
                w_low_idx = IDXW'(i);
        end
    end

    assign w_capture = (!r_first_valid || ack) && (|w_rise);

    always_ff @(posedge clock or negedge resetBar) begin
        if (!resetBar) begin
            r_q           <= INIT;
            r_changed     <= '0;
            r_first_valid <= 1'b0;
            r_first_index <= '0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= w_q_next ^ r_q;
            if (w_capture) begin
                r_first_valid <= 1'b1;
                r_first_index <= w_low_idx;
            end else if (ack) begin
                r_first_valid <= 1'b0;
            end
        end
    end

    assign q          = r_q;
    assign qBar       = ~r_q;
    assign changed    = r_changed;
    assign anySet     = |r_q;
    assign firstValid = r_first_valid;
    assign firstIndex = r_first_index;

endmodule

`default_nettype wire

// File: tb/tb_sr_flag_bank.sv
// ============================================================================
// Module   : tb_sr_flag_bank
// Purpose  : Scoreboard bench driving three flag banks (MODE 0/1/2) in parallel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_flag_bank;

    logic       clock = 1'b0;
    logic       resetBar = 1'b0;
    logic       tick = 1'b0, clear = 1'b0, preset = 1'b0, ack = 1'b0;
    logic [7:0] s = '0, r = '0;

    logic [7:0] q_o   [3];
    logic [7:0] qb_o  [3];
    logic [7:0] ch_o  [3];
    logic       any_o [3];
    logic       fv_o  [3];
    logic [2:0] idx_o [3];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0][7:0] q;
        logic [2:0][7:0] ch;
        logic            cc;
        logic            fv;
        logic [2:0]      idx;
        string           name;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;

    always #5 clock = ~clock;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        sr_flag_bank #(.WIDTH(8), .MODE(m), .INIT(8'hA5)) u_dut (
            .clock      (clock),
            .resetBar   (resetBar),
            .tick       (tick),
            .clear      (clear),
            .preset     (preset),
            .s          (s),
            .r          (r),
            .ack        (ack),
            .q          (q_o[m]),
            .qBar       (qb_o[m]),
            .changed    (ch_o[m]),
            .anySet     (any_o[m]),
            .firstValid (fv_o[m]),
            .firstIndex (idx_o[m])
        );
    end

    task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s mode%0d: got %h, expected %h", name, inst, act, want);
        end
    endtask

    // Monitor: pops one expectation per clock edge (or forced async sample).
    initial begin
        exp_t e;
        forever begin
            @(posedge clock or sample_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int m = 0; m < 3; m++) begin
                    chk({e.name, ".q"},       m, q_o[m],         e.q[m]);
                    chk({e.name, ".qBar"},    m, qb_o[m],        ~e.q[m]);
                    chk({e.name, ".changed"}, m, ch_o[m],        e.ch[m]);
                    chk({e.name, ".anySet"},  m, {7'd0, any_o[m]}, {7'd0, (e.q[m] != 8'h00)});
                    if (e.cc) begin
                        chk({e.name, ".firstValid"}, m, {7'd0, fv_o[m]},  {7'd0, e.fv});
                        chk({e.name, ".firstIndex"}, m, {5'd0, idx_o[m]}, {5'd0, e.idx});
                    end
                end
            end
        end
    end

    function automatic exp_t mk(input logic [7:0] q0, q1, q2, ch0, ch1, ch2,
                                input logic cc, fv, input logic [2:0] idx, input string name);
        exp_t e;
        e.q    = {q2, q1, q0};
        e.ch   = {ch2, ch1, ch0};
        e.cc   = cc;
        e.fv   = fv;
        e.idx  = idx;
        e.name = name;
        return e;
    endfunction

    task automatic step(input logic tk, cl, pr, ak, input logic [7:0] sv, rv,
                        input logic [7:0] q0, q1, q2, ch0, ch1, ch2,
                        input logic cc, fv, input logic [2:0] idx, input string name);
        @(negedge clock);
        tick = tk; clear = cl; preset = pr; ack = ak; s = sv; r = rv;
        exp_q.push_back(mk(q0, q1, q2, ch0, ch1, ch2, cc, fv, idx, name));
    endtask

    // Reset pulse between edges: state must be at reset values with no clock,
    // and the first edge after release must show no strobe.
    task automatic reset_pulse(input string name);
        @(negedge clock);
        tick = 0; clear = 0; preset = 0; ack = 0; s = '0; r = '0;
        resetBar = 1'b0;
        #1;
        exp_q.push_back(mk(8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, {name, "_async"}));
        -> sample_ev;
        #2;
        resetBar = 1'b1;
        exp_q.push_back(mk(8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, {name, "_first_edge"}));
    endtask

    initial begin
        int guard;
        reset_pulse("reset");
        step(0,0,0,0, 8'h00, 8'h00, 8'hA5,8'hA5,8'hA5, 8'h00,8'h00,8'h00, 1,0,3'd0, "idle");
        step(0,1,0,0, 8'h00, 8'h00, 8'h00,8'h00,8'h00, 8'hA5,8'hA5,8'hA5, 1,0,3'd0, "clear");
        // Conflict sweep s=r=01
        step(1,0,0,0, 8'h01, 8'h01, 8'h00,8'h01,8'h01, 8'h00,8'h01,8'h01, 0,0,3'd0, "mode_e1");
        step(1,0,0,0, 8'h01, 8'h01, 8'h00,8'h01,8'h00, 8'h00,8'h00,8'h01, 0,0,3'd0, "mode_e2");
        step(1,0,0,0, 8'h01, 8'h01, 8'h00,8'h01,8'h01, 8'h00,8'h00,8'h01, 0,0,3'd0, "mode_e3");
        step(1,0,0,0, 8'h00, 8'h00, 8'h00,8'h01,8'h01, 8'h00,8'h00,8'h00, 0,0,3'd0, "hold");
        step(0,1,0,1, 8'h00, 8'h00, 8'h00,8'h00,8'h00, 8'h00,8'h01,8'h01, 1,0,3'd0, "clear_ack");
        // First-event capture
        step(1,0,0,0, 8'h28, 8'h00, 8'h28,8'h28,8'h28, 8'h28,8'h28,8'h28, 1,1,3'd3, "cap_first");
        step(1,0,0,0, 8'h80, 8'h00, 8'hA8,8'hA8,8'hA8, 8'h80,8'h80,8'h80, 1,1,3'd3, "cap_ignore");
        step(1,0,0,1, 8'h00, 8'h00, 8'hA8,8'hA8,8'hA8, 8'h00,8'h00,8'h00, 1,0,3'd3, "cap_ack");
        step(1,0,0,0, 8'h00, 8'hFF, 8'h00,8'h00,8'h00, 8'hA8,8'hA8,8'hA8, 1,0,3'd3, "reset_bits");
        step(1,0,0,0, 8'h08, 8'h00, 8'h08,8'h08,8'h08, 8'h08,8'h08,8'h08, 1,1,3'd3, "cap_again");
        step(1,0,0,1, 8'h40, 8'h00, 8'h48,8'h48,8'h48, 8'h40,8'h40,8'h40, 1,1,3'd6, "ack_collide");
        // Priority and tick gating
        step(1,0,0,0, 8'h0F, 8'hF0, 8'h0F,8'h0F,8'h0F, 8'h47,8'h47,8'h47, 1,1,3'd6, "load_0F");
        step(0,0,0,0, 8'hF0, 8'h00, 8'h0F,8'h0F,8'h0F, 8'h00,8'h00,8'h00, 1,1,3'd6, "tick_low");
        step(0,1,1,0, 8'h00, 8'h00, 8'h00,8'h00,8'h00, 8'h0F,8'h0F,8'h0F, 1,1,3'd6, "clr_pre");
        step(0,0,1,1, 8'h00, 8'hFF, 8'hFF,8'hFF,8'hFF, 8'hFF,8'hFF,8'hFF, 1,1,3'd0, "preset_ack");
        reset_pulse("mid_reset");
        step(0,0,0,0, 8'h00, 8'h00, 8'hA5,8'hA5,8'hA5, 8'h00,8'h00,8'h00, 1,0,3'd0, "post_reset");

        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
